// File: rtl/reg_write_buffer_pkg.sv
// Shared definitions for the register write-back buffer slice: datapath
// widths, index limits and the register-file command selection.
package reg_write_buffer_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_MSB   = DATA_WIDTH - 1;
    localparam int unsigned ADDR_MSB   = REG_ADDR_W - 1;

    typedef enum logic [1:0] {
        RF_CMD_IDLE,
        RF_CMD_READ,
        RF_CMD_WRITE
    } rf_cmd_e;

    // Operand reads always win the register-file port; draining waits.
    function automatic rf_cmd_e rf_cmd_sel(input logic rd_req, input logic pending);
        if (rd_req)
            return RF_CMD_READ;
        else if (pending)
            return RF_CMD_WRITE;
        else
            return RF_CMD_IDLE;
    endfunction

endpackage

// File: rtl/reg_write_buffer_fwd_match.sv
// Youngest-wins address comparator over the pending write entries plus the
// write being accepted in the same cycle.
module reg_wb_fwd_match
    import reg_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic [ADDR_MSB:0]          rd_addr,
    input  logic [ADDR_MSB:0]          ent_addr [DEPTH],
    input  logic [DATA_MSB:0]          ent_data [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   head,
    input  logic [3:0]                 count,
    input  logic                       push,
    input  logic [ADDR_MSB:0]          push_addr,
    input  logic [DATA_MSB:0]          push_data,
    output logic                       hit,
    output logic [DATA_MSB:0]          data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    // Walk entries oldest to youngest so later matches override earlier ones;
    // the incoming push is younger than everything queued.
    always_comb begin
        logic [PTR_W-1:0] idx;
        hit  = 1'b0;
        data = '0;
        idx  = head;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (4'(i) < count && ent_addr[idx] == rd_addr) begin
                hit  = 1'b1;
                data = ent_data[idx];
            end
            idx = idx + PTR_W'(1);
        end
        if (push && push_addr == rd_addr) begin
            hit  = 1'b1;
            data = push_data;
        end
    end

endmodule

// File: rtl/reg_write_buffer.sv
// Register write-back buffer: queues datapath results in a small FIFO,
// drains them to the register file when no operand read is pending, and
// forwards pending values to operand reads through registered outputs.
module reg_write_buffer
    import reg_write_buffer_pkg::*;
#(
    parameter int unsigned WB_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WB_VALID,
    input  logic [ADDR_MSB:0] WB_ADDR,
    input  logic [DATA_MSB:0] WB_DATA,
    output logic              WB_READY,
    input  logic              RD_REQ,
    input  logic [ADDR_MSB:0] RD_ADDR1,
    input  logic [ADDR_MSB:0] RD_ADDR2,
    output logic              RF_READ,
    output logic              RF_WRITE,
    output logic [ADDR_MSB:0] RF_ADDR_W,
    output logic [DATA_MSB:0] RF_DATA_W,
    output logic              FWD_HIT1,
    output logic              FWD_HIT2,
    output logic [DATA_MSB:0] FWD_DATA1,
    output logic [DATA_MSB:0] FWD_DATA2,
    output logic [3:0]        COUNT,
    output logic              EMPTY
);

    localparam int unsigned PTR_W     = $clog2(WB_DEPTH);
    localparam logic [3:0]  DEPTH_CNT = 4'(WB_DEPTH);

    logic [ADDR_MSB:0] addr_q [WB_DEPTH];
    logic [DATA_MSB:0] data_q [WB_DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [3:0]        count;
    logic              push;
    logic              pop;
    rf_cmd_e           rf_cmd;
    logic              hit1, hit2;
    logic [DATA_MSB:0] data1, data2;

    // Command selection and head presentation toward the register file.
    always_comb begin
        WB_READY  = (count < DEPTH_CNT);
        push      = WB_VALID && WB_READY;
        rf_cmd    = rf_cmd_sel(RD_REQ, count != '0);
        RF_READ   = (rf_cmd == RF_CMD_READ);
        RF_WRITE  = (rf_cmd == RF_CMD_WRITE);
        pop       = RF_WRITE;
        RF_ADDR_W = RF_WRITE ? addr_q[head] : '0;
        RF_DATA_W = RF_WRITE ? data_q[head] : '0;
        COUNT     = count;
        EMPTY     = (count == '0);
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < WB_DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (push) begin
                addr_q[tail] <= WB_ADDR;
                data_q[tail] <= WB_DATA;
                tail         <= tail + PTR_W'(1);
            end
            if (pop)
                head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    reg_wb_fwd_match #(.DEPTH(WB_DEPTH)) u_match1 (
        .rd_addr   (RD_ADDR1),
        .ent_addr  (addr_q),
        .ent_data  (data_q),
        .head      (head),
        .count     (count),
        .push      (push),
        .push_addr (WB_ADDR),
        .push_data (WB_DATA),
        .hit       (hit1),
        .data      (data1)
    );

    reg_wb_fwd_match #(.DEPTH(WB_DEPTH)) u_match2 (
        .rd_addr   (RD_ADDR2),
        .ent_addr  (addr_q),
        .ent_data  (data_q),
        .head      (head),
        .count     (count),
        .push      (push),
        .push_addr (WB_ADDR),
        .push_data (WB_DATA),
        .hit       (hit2),
        .data      (data2)
    );

    // Forwarding results are captured only on read cycles and held otherwise.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            FWD_HIT1  <= 1'b0;
            FWD_HIT2  <= 1'b0;
            FWD_DATA1 <= '0;
            FWD_DATA2 <= '0;
        end else if (RD_REQ) begin
            FWD_HIT1  <= hit1;
            FWD_HIT2  <= hit2;
            FWD_DATA1 <= data1;
            FWD_DATA2 <= data2;
        end
    end

endmodule

// File: tb/tb_reg_write_buffer.sv
// Directed self-checking bench for reg_write_buffer with a write scoreboard.
module tb_reg_write_buffer;

    logic        CLK;
    logic        RST;
    logic        WB_VALID;
    logic [4:0]  WB_ADDR;
    logic [31:0] WB_DATA;
    logic        WB_READY;
    logic        RD_REQ;
    logic [4:0]  RD_ADDR1, RD_ADDR2;
    logic        RF_READ, RF_WRITE;
    logic [4:0]  RF_ADDR_W;
    logic [31:0] RF_DATA_W;
    logic        FWD_HIT1, FWD_HIT2;
    logic [31:0] FWD_DATA1, FWD_DATA2;
    logic [3:0]  COUNT;
    logic        EMPTY;

    reg_write_buffer #(.WB_DEPTH(4)) dut (
        .CLK(CLK), .RST(RST),
        .WB_VALID(WB_VALID), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA), .WB_READY(WB_READY),
        .RD_REQ(RD_REQ), .RD_ADDR1(RD_ADDR1), .RD_ADDR2(RD_ADDR2),
        .RF_READ(RF_READ), .RF_WRITE(RF_WRITE), .RF_ADDR_W(RF_ADDR_W), .RF_DATA_W(RF_DATA_W),
        .FWD_HIT1(FWD_HIT1), .FWD_HIT2(FWD_HIT2), .FWD_DATA1(FWD_DATA1), .FWD_DATA2(FWD_DATA2),
        .COUNT(COUNT), .EMPTY(EMPTY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         sb[$];
    int          total = 0;
    int          bad   = 0;
    logic        e_h1, e_h2;
    logic [31:0] e_d1, e_d2;
    logic [31:0] ref_rf [32];
    logic [31:0] dut_rf [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs against the
    // model, advance the edge, then check registered forwarding outputs.
    task automatic cycle(input logic vld, input logic [4:0] wa, input logic [31:0] wd,
                         input logic rd, input logic [4:0] ra1, input logic [4:0] ra2);
        logic acc, exp_w;
        wr_t  w;
        WB_VALID = vld; WB_ADDR = wa; WB_DATA = wd;
        RD_REQ = rd; RD_ADDR1 = ra1; RD_ADDR2 = ra2;
        #2;
        acc   = vld && (sb.size() < 4);
        exp_w = !rd && (sb.size() != 0);
        chk("wb_ready", 32'(WB_READY), 32'(sb.size() < 4));
        chk("count", 32'(COUNT), 32'(sb.size()));
        chk("empty", 32'(EMPTY), 32'(sb.size() == 0));
        chk("rf_read", 32'(RF_READ), 32'(rd));
        chk("rf_excl", 32'(RF_READ & RF_WRITE), 32'(0));
        chk("rf_write", 32'(RF_WRITE), 32'(exp_w));
        if (RF_WRITE === 1'b1) dut_rf[RF_ADDR_W] = RF_DATA_W;
        if (exp_w) begin
            w = sb.pop_front();
            ref_rf[w.a] = w.d;
            chk("rf_addr_w", 32'(RF_ADDR_W), 32'(w.a));
            chk("rf_data_w", RF_DATA_W, w.d);
        end else begin
            chk("rf_addr_w_idle", 32'(RF_ADDR_W), 32'(0));
            chk("rf_data_w_idle", RF_DATA_W, 32'(0));
        end
        if (rd) begin
            e_h1 = 1'b0; e_d1 = '0; e_h2 = 1'b0; e_d2 = '0;
            foreach (sb[i]) begin
                if (sb[i].a == ra1) begin e_h1 = 1'b1; e_d1 = sb[i].d; end
                if (sb[i].a == ra2) begin e_h2 = 1'b1; e_d2 = sb[i].d; end
            end
            if (acc && wa == ra1) begin e_h1 = 1'b1; e_d1 = wd; end
            if (acc && wa == ra2) begin e_h2 = 1'b1; e_d2 = wd; end
        end
        if (acc) begin
            w.a = wa; w.d = wd;
            sb.push_back(w);
        end
        @(posedge CLK);
        #1;
        chk("fwd_hit1", 32'(FWD_HIT1), 32'(e_h1));
        chk("fwd_data1", FWD_DATA1, e_d1);
        chk("fwd_hit2", 32'(FWD_HIT2), 32'(e_h2));
        chk("fwd_data2", FWD_DATA2, e_d2);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        for (int r = 0; r < 32; r++) begin ref_rf[r] = '0; dut_rf[r] = '0; end
        e_h1 = 1'b0; e_h2 = 1'b0; e_d1 = '0; e_d2 = '0;
        RST = 1'b0; WB_VALID = 1'b0; WB_ADDR = '0; WB_DATA = '0;
        RD_REQ = 1'b0; RD_ADDR1 = '0; RD_ADDR2 = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_count", 32'(COUNT), 32'(0));
        chk("rst_empty", 32'(EMPTY), 32'(1));
        chk("rst_ready", 32'(WB_READY), 32'(1));
        chk("rst_fwd_hit1", 32'(FWD_HIT1), 32'(0));
        chk("rst_fwd_data2", FWD_DATA2, 32'(0));
        RST = 1'b1;

        // Single drain with minimum latency.
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);

        // Fill while reads stall draining; fifth write refused.
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 5'(10 + i), 32'(32'h1000 + i), 1'b1, 5'd11, 5'd14);
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);

        // Youngest matching write wins; unmatched operand reports zero.
        cycle(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 5'd8);
        cycle(1'b1, 5'd7, 32'h22, 1'b1, 5'd7, 5'd8);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd8);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd8);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd8);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd8);

        // Same-cycle push forwards into an empty buffer; register 0 matches too.
        cycle(1'b1, 5'd3, 32'hAB, 1'b1, 5'd0, 5'd3);
        cycle(1'b1, 5'd0, 32'h5A5A, 1'b1, 5'd0, 5'd3);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3);

        // Reset in the middle of a drain discards everything asynchronously.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 5'(20 + i), 32'(32'hC0 + i), 1'b1, 5'd20, 5'd22);
        WB_VALID = 1'b0; RD_REQ = 1'b0;
        #2;
        chk("pre_rst_rf_write", 32'(RF_WRITE), 32'(1));
        RST = 1'b0;
        #1;
        chk("mid_rst_count", 32'(COUNT), 32'(0));
        chk("mid_rst_empty", 32'(EMPTY), 32'(1));
        chk("mid_rst_rf_write", 32'(RF_WRITE), 32'(0));
        chk("mid_rst_fwd_hit1", 32'(FWD_HIT1), 32'(0));
        chk("mid_rst_fwd_data1", FWD_DATA1, 32'(0));
        sb.delete();
        e_h1 = 1'b0; e_h2 = 1'b0; e_d1 = '0; e_d2 = '0;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        cycle(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);

        // Pointer wrap with interleaved reads and random writes.
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 5'($urandom_range(0, 31)), $urandom, 1'(i % 2 == 0),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        for (int k = 0; k < 20 && sb.size() != 0; k++)
            cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
        #2;
        chk("final_count", 32'(COUNT), 32'(0));
        chk("final_empty", 32'(EMPTY), 32'(1));
        for (int r = 0; r < 32; r++)
            chk($sformatf("rf_reg%0d", r), dut_rf[r], ref_rf[r]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
